// File: rtl/sum_tx_sequencer.sv
// -----------------------------------------------------------------------------
// sum_tx_sequencer
//
// Captures two operands (A, B) from a shared switch bus on active-low save
// strobes, keeps their live sum on sum_out, and on a transmit request sends a
// snapshot of the sum as ASCII decimal digits through a byte-wide UART core.
// The UART core uses a start/busy handshake.
//
// Optional build macro:
//   SUM_SEQ_CRLF_EN - when defined, each frame is tens, ones, CR (0x0D),
//                     LF (0x0A). When undefined, each frame is tens, ones.
//
// Parameters:
//   DATA_W      operand width, 1..5 (sum <= 62 fits in two decimal digits)
//   SYNC_STAGES synchronizer depth for the asynchronous pins, >= 2
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   save_a_n    active-low strobe, falling edge loads data_input into A
//   save_b_n    active-low strobe, falling edge loads data_input into B
//   data_input  operand value from the switches
//   uart_tx_en  active-high request, rising edge starts a frame (IDLE only)
//   tx_busy     UART core busy flag
//   tx_start    one-cycle request to the UART core to send tx_data
//   tx_data     byte presented to the UART core
//   sum_out     live A+B, unsigned, DATA_W+1 bits
//   seq_busy    high from frame acceptance until the last byte completes
// -----------------------------------------------------------------------------
module sum_tx_sequencer #(
  parameter int DATA_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              save_a_n,
  input  logic              save_b_n,
  input  logic [DATA_W-1:0] data_input,
  input  logic              uart_tx_en,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [DATA_W:0]   sum_out,
  output logic              seq_busy
);

`ifdef SUM_SEQ_CRLF_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam logic [1:0] LAST_IDX = 2'd1;
`endif

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SEND      = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Pin synchronizers. Strobes idle high, the request idles low, so the reset
  // values match the idle levels and no edge is seen coming out of reset.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sa_sync_reg, sb_sync_reg, en_sync_reg;
  logic [SYNC_STAGES-1:0] sa_sync_d, sb_sync_d, en_sync_d;

  assign sa_sync_d = {sa_sync_reg[SYNC_STAGES-2:0], save_a_n};
  assign sb_sync_d = {sb_sync_reg[SYNC_STAGES-2:0], save_b_n};
  assign en_sync_d = {en_sync_reg[SYNC_STAGES-2:0], uart_tx_en};

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sa_sync_reg[gi] <= 1'b1;
          sb_sync_reg[gi] <= 1'b1;
          en_sync_reg[gi] <= 1'b0;
        end else begin
          sa_sync_reg[gi] <= sa_sync_d[gi];
          sb_sync_reg[gi] <= sb_sync_d[gi];
          en_sync_reg[gi] <= en_sync_d[gi];
        end
      end
    end
  endgenerate

  // Previous synchronized values for edge detection.
  logic sa_prev_reg, sb_prev_reg, en_prev_reg;
  logic sa_fall, sb_fall, en_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sa_prev_reg <= 1'b1;
      sb_prev_reg <= 1'b1;
      en_prev_reg <= 1'b0;
    end else begin
      sa_prev_reg <= sa_sync_reg[SYNC_STAGES-1];
      sb_prev_reg <= sb_sync_reg[SYNC_STAGES-1];
      en_prev_reg <= en_sync_reg[SYNC_STAGES-1];
    end
  end

  assign sa_fall = sa_prev_reg & ~sa_sync_reg[SYNC_STAGES-1];
  assign sb_fall = sb_prev_reg & ~sb_sync_reg[SYNC_STAGES-1];
  assign en_rise = ~en_prev_reg & en_sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Operands and live sum. Saves are honoured in every state; the frame uses
  // its own snapshot so mid-frame saves never disturb bytes in flight.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] a_reg, b_reg;
  logic [DATA_W:0]   sum_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
    end else begin
      if (sa_fall) a_reg <= data_input;
      if (sb_fall) b_reg <= data_input;
      sum_reg <= {1'b0, a_reg} + {1'b0, b_reg};
    end
  end

  assign sum_out = sum_reg;

  // ---------------------------------------------------------------------------
  // Frame sequencer
  // ---------------------------------------------------------------------------
  state_t          state_reg, state_next;
  logic [1:0]      idx_reg, idx_next;
  logic [DATA_W:0] snap_reg, snap_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      idx_reg   <= 2'd0;
      snap_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      snap_reg  <= snap_next;
    end
  end

  // ASCII digits of the snapshot, computed in 8 bits.
  logic [7:0] snap_ext, tens_byte, ones_byte, cur_byte;

  assign snap_ext  = 8'(snap_reg);
  assign tens_byte = 8'h30 + (snap_ext / 8'd10);
  assign ones_byte = 8'h30 + (snap_ext % 8'd10);

  always_comb begin
    cur_byte = 8'h00;
    case (idx_reg)
      2'd0:    cur_byte = tens_byte;
      2'd1:    cur_byte = ones_byte;
`ifdef SUM_SEQ_CRLF_EN
      2'd2:    cur_byte = 8'h0D;
      2'd3:    cur_byte = 8'h0A;
`endif
      default: cur_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    snap_next  = snap_reg;
    tx_start   = 1'b0;
    tx_data    = 8'h00;
    seq_busy   = 1'b1;

    case (state_reg)
      IDLE: begin
        seq_busy = 1'b0;
        if (en_rise) state_next = LOAD;
      end
      LOAD: begin
        snap_next  = sum_reg;
        idx_next   = 2'd0;
        state_next = SEND;
      end
      SEND: begin
        tx_data = cur_byte;
        // Start is combinational on !tx_busy so the pulse is exactly the one
        // cycle in which the state machine leaves SEND.
        if (!tx_busy) begin
          tx_start   = 1'b1;
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        tx_data = cur_byte;
        if (tx_busy) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        tx_data = cur_byte;
        if (!tx_busy) begin
          if (idx_reg == LAST_IDX) begin
            state_next = IDLE;
            seq_busy   = 1'b0;
          end else begin
            idx_next   = idx_reg + 2'd1;
            state_next = SEND;
          end
        end
      end
      default: begin
        state_next = IDLE;
        seq_busy   = 1'b0;
      end
    endcase
  end

endmodule
